load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
//  Load-side companion to the store byte-lane formatter. Takes a load request from the
//  core (address, size, signedness), issues a word-aligned read to data memory over a
//  req/gnt + rvalid handshake, then picks the addressed byte or halfword lane and
//  sign- or zero-extends it to 32 bits for writeback (LB/LH/LW/LBU/LHU).
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT without mem_rvalid before ld_err; 0 = no timeout
// PORTS
//  clk          in   1   single clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  ld_valid     in   1   core load request; accepted when ld_valid & ld_ready
//  ld_ready     out  1   1 only in IDLE
//  ld_addr      in   32  byte address
//  ld_size      in   2   00 byte, 01 half, 10 word, 11 reserved (handled as word)
//  ld_unsigned  in   1   1 = zero-extend (LBU/LHU), 0 = sign-extend
//  mem_req      out  1   read request, held until mem_gnt
//  mem_addr     out  32  {addr[31:2],2'b00}, stable from accept until return to IDLE
//  mem_gnt      in   1   request accepted by memory
//  mem_rvalid   in   1   read data valid
//  mem_rdata    in   32  read word
//  rd_valid     out  1   one-cycle pulse, rd_data valid
//  rd_data      out  32  extended load result; holds until next rd_valid/ld_err
//  ld_err       out  1   one-cycle pulse: timeout (or misalignment, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; ld_ready=1; mem_req=0, mem_addr=0, rd_valid=0, rd_data=0,
//    ld_err=0, timeout counter=0. Reset mid-transfer aborts it; a later mem_rvalid is ignored.
//  - On accept, latch offset=ld_addr[1:0], size, unsigned; mem_addr set.
//  - FSM: IDLE -ld_valid-> REQ; REQ (mem_req=1) -mem_gnt-> WAIT;
//    WAIT -mem_rvalid-> RESP; RESP (rd_valid=1, 1 cycle) -> IDLE;
//    ERR (ld_err=1, rd_data=0, 1 cycle) -> IDLE.
//  - mem_rvalid is sampled only in WAIT; an rvalid coincident with mem_gnt is ignored.
//  - Min latency: accept at T, gnt at T+1, rvalid at T+2, rd_valid at T+3.
//  - Byte: lane = offset; bits 31:8 = unsigned ? 0 : lane[7].
//  - Half: lane = offset[1] ? rdata[31:16] : rdata[15:0]; bits 31:16 = unsigned ? 0 : lane[15].
//  - Word/reserved: rd_data = mem_rdata; ld_unsigned ignored.
//  - Timeout: counter clears on entering WAIT and increments each WAIT cycle. When the
//    counter reaches TIMEOUT_CYCLES without rvalid -> ERR. rvalid in the same cycle wins.
//  - rd_valid and ld_err are never both high.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with offset[0]=1, or word/reserved with offset!=0,
//    goes IDLE -> ERR directly; no mem_req is issued.
//  Not defined: offset[0] ignored for half; offset ignored for word (read the aligned word).
// TESTING
//  1 LB addr 0x103, rdata 0x80FF_1234 -> rd_data 0xFFFF_FF80 at T+3, mem_addr 0x100
//  2 LHU addr 0x202, rdata 0x9ABC_5678 -> rd_data 0x0000_9ABC; LH same -> 0xFFFF_9ABC
//  3 LW, mem_gnt delayed 3 cycles, rvalid 2 cycles later -> mem_req held 4 cycles,
//    rd_valid one pulse, ld_ready low until RESP exits
//  4 TIMEOUT_CYCLES=4, no rvalid -> ld_err pulse after 4 WAIT cycles, rd_data=0, back to IDLE
//  5 rst asserted in WAIT, then mem_rvalid -> no rd_valid, outputs at reset values
//  6 LH addr 0x101: with macro -> ld_err, no mem_req; without -> low half returned

Source files
------------

// File: rtl/load_align_unit_if.sv
// Load align unit bus: core load request/result plus data-memory read port.
// slave = the load unit itself, master = the core/memory side driving it.
interface load_align_unit_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        ld_err;

  modport slave (
    input  ld_valid, ld_addr, ld_size, ld_unsigned,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, mem_req, mem_addr,
    output rd_valid, rd_data, ld_err
  );

  modport master (
    output ld_valid, ld_addr, ld_size, ld_unsigned,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, mem_req, mem_addr,
    input  rd_valid, rd_data, ld_err
  );
endinterface

// File: rtl/load_align_unit.sv
// Load align unit: word-aligned memory read, lane select, sign/zero extend.
// Ports: clk, rst (sync, active-high), bus (load_align_unit_if.slave).
// Param TIMEOUT_CYCLES (0 = none). Macro LSU_MISALIGN_TRAP_EN traps misaligned loads.
module load_align_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  load_align_unit_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 :
                      $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = (bus.ld_size == 2'b01 && bus.ld_addr[0]) ||
                 (bus.ld_size[1] && bus.ld_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // Lane select uses the offset latched at accept time.
  always_comb begin
    lane_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus.mem_rdata[31:16]
                      : bus.mem_rdata[15:0];
    ext    = bus.mem_rdata;
    unique case (1'b1)
      (size_q == 2'b00):
        ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      (size_q == 2'b01):
        ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default:
        ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ld_valid) begin
          addr_d = {bus.ld_addr[31:2], 2'b00};
          off_d  = bus.ld_addr[1:0];
          size_d = bus.ld_size;
          uns_d  = bus.ld_unsigned;
          if (misal) begin
            state_d = S_ERR;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // rvalid wins over a same-cycle timeout
        if (bus.mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = ext;
        end else if (TIMEOUT_CYCLES != 0 &&
                     cnt_q + CW'(1) == TMO) begin
          state_d = S_ERR;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ld_ready = (state_q == S_IDLE);
  assign bus.mem_req  = (state_q == S_REQ);
  assign bus.mem_addr = addr_q;
  assign bus.rd_valid = (state_q == S_RESP);
  assign bus.rd_data  = rdata_q;
  assign bus.ld_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_load_align_unit.sv
// Testbench for load_align_unit: directed cases plus random loads
// checked against an arithmetic reference model.
module tb_load_align_unit;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] last_rd = '0;

  load_align_unit_if lif();

  load_align_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] w,
                                           logic [31:0] a,
                                           logic [1:0] sz,
                                           logic u);
    longint v;
    if (sz == 2'd0) begin
      v = longint'((w >> (8 * a[1:0])) & 32'hFF);
      if (!u && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((w >> (16 * a[1])) & 32'hFFFF);
      if (!u && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic bit trap(logic [31:0] a, logic [1:0] sz);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, lif.ld_ready, 1);
    check({tag, "_req"}, lif.mem_req, 0);
    check({tag, "_maddr"}, lif.mem_addr, 0);
    check({tag, "_rdv"}, lif.rd_valid, 0);
    check({tag, "_rdd"}, lif.rd_data, 0);
    check({tag, "_err"}, lif.ld_err, 0);
  endtask

  task automatic do_load(input logic [31:0] a,
                         input logic [1:0] sz,
                         input logic u,
                         input int gd,
                         input int rv,
                         input logic [31:0] w);
    logic [31:0] exp;
    int n;
    int last_k;
    bit to;
    n = 0;
    while (!lif.ld_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready", lif.ld_ready, 1);
    lif.ld_valid    = 1'b1;
    lif.ld_addr     = a;
    lif.ld_size     = sz;
    lif.ld_unsigned = u;
    @(posedge clk); #1;
    lif.ld_valid    = 1'b0;
    lif.ld_addr     = $urandom;
    lif.ld_size     = 2'($urandom);
    lif.ld_unsigned = 1'($urandom);
    if (trap(a, sz)) begin
      check("trap_err", lif.ld_err, 1);
      check("trap_req", lif.mem_req, 0);
      check("trap_rdv", lif.rd_valid, 0);
      check("trap_data", lif.rd_data, 0);
      last_rd = '0;
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check("req", lif.mem_req, 1);
        check("maddr", lif.mem_addr, {a[31:2], 2'b00});
        check("rdy_lo", lif.ld_ready, 0);
        if (i == gd) begin
          lif.mem_gnt    = 1'b1;
          lif.mem_rvalid = 1'b1;
          lif.mem_rdata  = ~w;
        end
        @(posedge clk); #1;
      end
      lif.mem_gnt    = 1'b0;
      lif.mem_rvalid = 1'b0;
      to = (rv >= TMO);
      last_k = to ? TMO - 1 : rv;
      for (int k = 0; k <= last_k; k++) begin
        check("wait_req", lif.mem_req, 0);
        check("wait_out", {lif.rd_valid, lif.ld_err}, 0);
        check("wait_maddr", lif.mem_addr, {a[31:2], 2'b00});
        if (k == rv) begin
          lif.mem_rvalid = 1'b1;
          lif.mem_rdata  = w;
        end
        @(posedge clk); #1;
      end
      lif.mem_rvalid = 1'b0;
      lif.mem_rdata  = $urandom;
      if (to) begin
        check("to_err", lif.ld_err, 1);
        check("to_rdv", lif.rd_valid, 0);
        check("to_data", lif.rd_data, 0);
        last_rd = '0;
      end else begin
        exp = ref_load(w, a, sz, u);
        check("rd_valid", lif.rd_valid, 1);
        check("rd_noerr", lif.ld_err, 0);
        check("rd_data", lif.rd_data, exp);
        check("rd_rdy_lo", lif.ld_ready, 0);
        last_rd = exp;
      end
    end
    @(posedge clk); #1;
    check("pulse", {lif.rd_valid, lif.ld_err}, 0);
    check("idle_rdy", lif.ld_ready, 1);
    check("hold", lif.rd_data, last_rd);
  endtask

  initial begin
    lif.ld_valid    = 1'b0;
    lif.ld_addr     = '0;
    lif.ld_size     = '0;
    lif.ld_unsigned = 1'b0;
    lif.mem_gnt     = 1'b0;
    lif.mem_rvalid  = 1'b0;
    lif.mem_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("rst0");

    // LB sign-extend
    do_load(32'h0000_0103, 2'd0, 1'b0, 0, 0, 32'h80FF_1234);
    // LHU / LH upper half
    do_load(32'h0000_0202, 2'd1, 1'b1, 0, 0, 32'h9ABC_5678);
    do_load(32'h0000_0202, 2'd1, 1'b0, 0, 0, 32'h9ABC_5678);
    // LW with delayed gnt and rvalid
    do_load(32'h0000_0300, 2'd2, 1'b0, 3, 2, 32'hDEAD_BEEF);
    // timeout, and rvalid on the last allowed cycle
    do_load(32'h0000_0400, 2'd2, 1'b0, 1, 99, 32'h1111_2222);
    do_load(32'h0000_0404, 2'd2, 1'b0, 0, TMO - 1, 32'h3333_4444);
    // misaligned half
    do_load(32'h0000_0101, 2'd1, 1'b0, 0, 0, 32'h9ABC_5678);
    // reserved size as word
    do_load(32'h0000_0508, 2'd3, 1'b1, 0, 1, 32'hF0F0_0F0F);

    // reset while in WAIT, then a stale rvalid
    lif.ld_valid = 1'b1;
    lif.ld_addr  = 32'h0000_0600;
    lif.ld_size  = 2'd2;
    @(posedge clk); #1;
    lif.ld_valid = 1'b0;
    lif.mem_gnt  = 1'b1;
    @(posedge clk); #1;
    lif.mem_gnt  = 1'b0;
    check("rst_inwait_req", lif.mem_req, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst1");
    lif.mem_rvalid = 1'b1;
    lif.mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    lif.mem_rvalid = 1'b0;
    check_reset_vals("rst2");
    @(posedge clk); #1;
    check_reset_vals("rst3");
    last_rd = '0;

    for (int r = 0; r < 60; r++) begin
      do_load($urandom, 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 5)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
